// File: rtl/fifo_4x8.sv
// fifo_4x8: single-clock synchronous FIFO, normal (non-showahead) read mode.
// Registered q, empty and full flags, plus an occupancy count.
// Asynchronous active-low reset clears control state and q, but not the storage array.
// DEPTH must be a power of two and at least 2.
module fifo_4x8 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           data,
    input  logic                       wrreq,
    input  logic                       rdreq,
    output logic [WIDTH-1:0]           q,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH)-1:0]   usedw
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra bit; only the low AW bits address the array.
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] q_q,      q_d;
    logic             empty_q,  empty_d;
    logic             full_q,   full_d;

    logic             wr_en;
    logic             rd_en;

    // A request is accepted only when the registered flags allow it.
    assign wr_en = wrreq & ~full_q;
    assign rd_en = rdreq & ~empty_q;

    // Next-state for pointers, count, read data and flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        q_d      = q_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end

        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + ONE;
            q_d      = mem_q[rd_ptr_q[AW-1:0]];
        end

        if (wr_en && !rd_en) begin
            count_d = count_q + ONE;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - ONE;
        end

        // Flags follow the updated count so they line up with it.
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_FULL);
    end

    // Storage array write; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data;
        end
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            q_q      <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            q_q      <= q_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign q     = q_q;
    assign empty = empty_q;
    assign full  = full_q;
    // usedw wraps to 0 when full; full distinguishes that case from empty.
    assign usedw = count_q[AW-1:0];

endmodule

// File: tb/tb_fifo_4x8.sv
// tb_fifo_4x8: directed self-checking bench for fifo_4x8 (WIDTH=8, DEPTH=4).
module tb_fifo_4x8;

    logic       clock;
    logic       reset;
    logic [7:0] data;
    logic       wrreq;
    logic       rdreq;
    logic [7:0] q;
    logic       empty;
    logic       full;
    logic [1:0] usedw;

    int tests;
    int fails;

    fifo_4x8 #(.WIDTH(8), .DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .data  (data),
        .wrreq (wrreq),
        .rdreq (rdreq),
        .q     (q),
        .empty (empty),
        .full  (full),
        .usedw (usedw)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given requests; outputs sampled 1 time unit later.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wrreq = w;
        rdreq = r;
        data  = d;
        @(posedge clock);
        #1;
        wrreq = 1'b0;
        rdreq = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] eq, input logic ee,
                             input logic ef, input logic [1:0] eu);
        chk({tag, ".q"},     32'(q),     32'(eq));
        chk({tag, ".empty"}, 32'(empty), 32'(ee));
        chk({tag, ".full"},  32'(full),  32'(ef));
        chk({tag, ".usedw"}, 32'(usedw), 32'(eu));
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Reset held with both requests active: nothing may be accepted.
        reset = 1'b0;
        wrreq = 1'b1;
        rdreq = 1'b1;
        data  = 8'hDE;
        #12;
        chk_state("reset", 8'h00, 1'b1, 1'b0, 2'd0);
        @(negedge clock);
        wrreq = 1'b0;
        rdreq = 1'b0;
        reset = 1'b1;

        // Idle after reset.
        cyc(1'b0, 1'b0, 8'h00);
        chk_state("idle", 8'h00, 1'b1, 1'b0, 2'd0);

        // Three writes then three reads.
        cyc(1'b1, 1'b0, 8'h11);
        chk_state("w11", 8'h00, 1'b0, 1'b0, 2'd1);
        cyc(1'b1, 1'b0, 8'h22);
        chk("w22.usedw", 32'(usedw), 32'd2);
        cyc(1'b1, 1'b0, 8'h33);
        chk("w33.usedw", 32'(usedw), 32'd3);
        cyc(1'b0, 1'b1, 8'h00);
        chk_state("r11", 8'h11, 1'b0, 1'b0, 2'd2);
        cyc(1'b0, 1'b1, 8'h00);
        chk_state("r22", 8'h22, 1'b0, 1'b0, 2'd1);
        cyc(1'b0, 1'b1, 8'h00);
        chk_state("r33", 8'h33, 1'b1, 1'b0, 2'd0);

        // Read on empty is ignored; q holds.
        cyc(1'b0, 1'b1, 8'h00);
        chk_state("rd_empty", 8'h33, 1'b1, 1'b0, 2'd0);
        // Read plus write on empty: only the write is accepted.
        cyc(1'b1, 1'b1, 8'h44);
        chk_state("rw_empty", 8'h33, 1'b0, 1'b0, 2'd1);
        cyc(1'b0, 1'b1, 8'h00);
        chk_state("r44", 8'h44, 1'b1, 1'b0, 2'd0);

        // Fill to full; usedw wraps to 0.
        cyc(1'b1, 1'b0, 8'hA0);
        cyc(1'b1, 1'b0, 8'hA1);
        cyc(1'b1, 1'b0, 8'hA2);
        cyc(1'b1, 1'b0, 8'hA3);
        chk_state("full", 8'h44, 1'b0, 1'b1, 2'd0);
        // Write while full is ignored.
        cyc(1'b1, 1'b0, 8'hFF);
        chk_state("w_full", 8'h44, 1'b0, 1'b1, 2'd0);
        // Write plus read while full: only the read is accepted.
        cyc(1'b1, 1'b1, 8'hEE);
        chk_state("rw_full", 8'hA0, 1'b0, 1'b0, 2'd3);
        cyc(1'b0, 1'b1, 8'h00);
        chk("rA1.q", 32'(q), 32'hA1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("rA2.q", 32'(q), 32'hA2);
        cyc(1'b0, 1'b1, 8'h00);
        chk_state("rA3", 8'hA3, 1'b1, 1'b0, 2'd0);

        // Two entries held, then six simultaneous read+write edges across wrap.
        cyc(1'b1, 1'b0, 8'h4E);
        cyc(1'b1, 1'b0, 8'h4F);
        chk("two.usedw", 32'(usedw), 32'd2);
        begin
            logic [7:0] exp_q [6];
            exp_q = '{8'h4E, 8'h4F, 8'h50, 8'h51, 8'h52, 8'h53};
            for (int i = 0; i < 6; i++) begin
                cyc(1'b1, 1'b1, 8'(8'h50 + i));
                chk($sformatf("rw%0d.q", i), 32'(q), 32'(exp_q[i]));
                chk($sformatf("rw%0d.usedw", i), 32'(usedw), 32'd2);
            end
        end
        cyc(1'b0, 1'b1, 8'h00);
        chk("r54.q", 32'(q), 32'h54);
        cyc(1'b0, 1'b1, 8'h00);
        chk_state("r55", 8'h55, 1'b1, 1'b0, 2'd0);

        // Three entries held, then an asynchronous reset pulse between edges.
        cyc(1'b1, 1'b0, 8'h71);
        cyc(1'b1, 1'b0, 8'h72);
        cyc(1'b1, 1'b0, 8'h73);
        chk("three.usedw", 32'(usedw), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk_state("async_rst", 8'h00, 1'b1, 1'b0, 2'd0);
        #1;
        reset = 1'b1;
        cyc(1'b1, 1'b0, 8'h99);
        chk_state("post_w", 8'h00, 1'b0, 1'b0, 2'd1);
        cyc(1'b0, 1'b1, 8'h00);
        chk_state("post_r", 8'h99, 1'b1, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_4x8.md
FIFO_4X8 -- requirements
Module: fifo_4x8

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits.
REQ-002 Parameter DEPTH, default 4: storage entries; SHALL be a power of two, at least 2.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; 0 resets the FIFO immediately regardless of clock.
REQ-005 Port data, input, WIDTH: write data, sampled on a clock edge when the write is accepted.
REQ-006 Port wrreq, input, 1: write request, level-sensitive, one entry per accepting edge.
REQ-007 Port rdreq, input, 1: read request, level-sensitive, one entry per accepting edge.
REQ-008 Port q, output, WIDTH: read data register.
REQ-009 Port empty, output, 1: high when the occupancy is 0.
REQ-010 Port full, output, 1: high when the occupancy equals DEPTH.
REQ-011 Port usedw, output, log2(DEPTH): occupancy modulo DEPTH.

Function
REQ-012 Storage: DEPTH x WIDTH array, 3-bit write pointer and 3-bit read pointer (log2(DEPTH)+1 bits), and an occupancy counter of range 0..DEPTH.
REQ-013 Write accept: wrreq=1 and full=0 at the edge; data stored at the write pointer; write pointer increments and wraps from DEPTH-1 to 0.
REQ-014 Write while full: ignored; no storage, pointer or count change, even if rdreq=1 on the same edge.
REQ-015 Read accept: rdreq=1 and empty=0 at the edge; q loads the entry at the read pointer on that edge; read pointer increments with wrap.
REQ-016 Read latency: normal (non-showahead) mode; read data appears on q one clock after the rdreq edge.
REQ-017 Read while empty: ignored; q holds its value; pointers and count are unchanged, even if wrreq=1 on the same edge.
REQ-018 q holds its last value on every edge without an accepted read.
REQ-019 Simultaneous accepted read and write (0 < count < DEPTH): both are performed and the count is unchanged.
REQ-020 Count changes: +1 on a write-only accept, -1 on a read-only accept.
REQ-021 Flags are registered:
- empty = (count==0).
- full = (count==DEPTH).
- Both are valid in the same cycle as the updated count.
REQ-022 usedw is count[log2(DEPTH)-1:0], so usedw reads 0 when full; use full to tell full from empty.
REQ-023 Ordering is strict first-in first-out; no entry is lost or duplicated across pointer wrap-around.
REQ-024 No overflow or underflow of the internal count occurs under any input sequence.

Reset
REQ-025 Asserting reset (reset=0) SHALL asynchronously force:
- empty=1, full=0, usedw=0, q=0.
- Both pointers and the count to 0.
REQ-026 Array contents are not cleared by reset.
REQ-027 Reset asserted mid-operation discards all stored entries; after release the FIFO behaves as freshly empty.
REQ-028 wrreq and rdreq are ignored while reset=0.
REQ-029 The first accepting edge is the first rising clock edge after reset returns to 1.

Verification
REQ-030 Reset then idle -> empty=1, full=0, usedw=0, q=0.
REQ-031 Write 0x11, 0x22, 0x33 on consecutive edges -> usedw=1,2,3 and empty falls after the first write; then read three times -> q=0x11, 0x22, 0x33 one clock after each read edge, and empty=1 at the end.
REQ-032 Write 0xA0..0xA3 -> full=1, usedw=0; a fifth write of 0xFF is ignored; four reads return 0xA0..0xA3 in order.
REQ-033 Read on an empty FIFO with q=0x33 -> q stays 0x33 and usedw stays 0; a simultaneous wrreq with 0x44 is accepted and usedw becomes 1.
REQ-034 With 2 entries held, assert rdreq and wrreq together for 6 edges using data 0x50..0x55 -> usedw stays 2 and outputs continue in order across pointer wrap.
REQ-035 With 3 entries held, pulse reset low between clock edges -> empty=1 and usedw=0 immediately; the next write and read return the new data only.
